emisor_teclado: RTL and testbench
=================================

// Module: emisor_teclado
// PURPOSE
// - Keypad-side transmitter for the cashier FSM: drives tarjeta_recibida, tipo_trans, digito/digito_stb, monto_stb.
// - Host supplies PIN (4 BCD digits), amount (8 BCD digits) and transaction type. Block sequences one full session.
// - Session order: card insert, PIN entry, amount entry, result wait. Reports outcome to host via done/status.
// - Sits between the test/host layer and cajero; the other end of the digit-strobe protocol.
// PARAMETERS
// - GAP_CYCLES     default 2    idle cycles between consecutive digito_stb pulses (0 = back-to-back)
// - INSERT_CYCLES  default 4    cycles tarjeta_recibida is high before first PIN digit
// - RESP_TIMEOUT   default 16   cycles to wait for an ATM response after PIN / after monto_stb
// PORTS
// - clock                 in   1   rising-edge clock
// - reset                 in   1   synchronous, active-high
// - start                 in   1   1-cycle request; sampled only in IDLE
// - pin_in                in   16  PIN, 4 BCD nibbles, [15:12] sent first
// - monto_in              in   32  amount, 8 BCD nibbles, [31:28] sent first
// - tipo_in               in   1   0 = deposit, 1 = withdrawal
// - pin_incorrecto        in   1   ATM: last PIN wrong
// - bloqueo               in   1   ATM: cashier blocked
// - entregar_dinero       in   1   ATM: cash dispensed
// - fondos_insuficientes  in   1   ATM: withdrawal refused
// - tarjeta_recibida      out  1   card present, high from INSERT through WAIT_RES
// - tipo_trans            out  1   latched tipo_in, valid while tarjeta_recibida high
// - digito_stb            out  1   1-cycle digit strobe
// - digito                out  4   digit value when digito_stb=1, else 4'hF
// - monto_stb             out  1   1-cycle pulse, GAP_CYCLES+1 cycles after last amount digit
// - busy                  out  1   high in every state except IDLE
// - done                  out  1   1-cycle pulse on return to IDLE
// - status                out  3   outcome, valid with done, held until next start
// BEHAVIOUR
// - Reset values: all outputs 0 except digito=4'hF. FSM to IDLE. Counters cleared.
// - start in IDLE: latch pin_in/monto_in/tipo_in, go INSERT next cycle. start while busy: ignored.
// - INSERT: tarjeta_recibida=1 for INSERT_CYCLES cycles, then SEND_PIN.
// - SEND_PIN: first strobe on the first cycle in state. Strobes every GAP_CYCLES+1 cycles, 4 digits MSB-first.
// - After 4th strobe go WAIT_PIN and start the timeout counter.
// - WAIT_PIN: pin_incorrecto -> status=1, FINISH. bloqueo -> status=2, FINISH.
// - WAIT_PIN: after RESP_TIMEOUT cycles with no event, go SEND_AMT.
// - SEND_AMT: 8 digits, same timing as PIN. monto_stb follows GAP_CYCLES+1 cycles after the 8th strobe.
// - After monto_stb go WAIT_RES.
// - WAIT_RES: bloqueo -> 2. fondos_insuficientes -> 3. entregar_dinero -> 0 (withdrawal).
// - WAIT_RES timeout: deposit -> status=0. Withdrawal -> status=4 (no response).
// - Simultaneous ATM inputs, priority: bloqueo > pin_incorrecto > fondos_insuficientes > entregar_dinero.
// - bloqueo in any non-IDLE state: abort immediately to FINISH, status=2. Strobes stop the same cycle.
// - FINISH (1 cycle): tarjeta_recibida=0, done=1, then IDLE.
// - digito_stb and monto_stb are never high together. No strobe outside SEND_PIN/SEND_AMT.
// - Counters: gap counter sized for GAP_CYCLES, digit index 0..7, timeout counter sized for RESP_TIMEOUT. No wrap.
// - Reset mid-session: drop tarjeta_recibida and all strobes the next cycle. No done pulse.
// CONFIGURATION
// - TECLADO_BCD_CHECK_EN defined:
//   - In the start cycle, any latched nibble >4'h9 in pin_in or monto_in rejects the session.
//   - Rejected session: no INSERT, done pulses 2 cycles after start, status=5.
//   - tarjeta_recibida and strobes never assert for the rejected session.
// - TECLADO_BCD_CHECK_EN undefined: nibbles sent unchecked. Status 5 never produced.
// TESTING
// - GAP=2, INSERT=4, pin 16'h1234, no ATM response, deposit:
//   - 1,2,3,4 strobed at cycles t0, t0+3, t0+6, t0+9.
//   - After amount + monto_stb and 16-cycle timeout: done with status=0.
// - Withdrawal, monto 32'h00000500:
//   - 8 strobes 0,0,0,0,0,5,0,0, then monto_stb 3 cycles after the last strobe.
//   - entregar_dinero 5 cycles later -> status=0.
// - pin_incorrecto 2 cycles after 4th PIN strobe:
//   - No amount digits sent. tarjeta_recibida falls. done with status=1.
// - bloqueo during 3rd amount digit gap:
//   - No further strobes, no monto_stb. done the next cycle, status=2.
// - Misc:
//   - start while busy: ignored, session unaffected.
//   - reset after 2nd PIN strobe: outputs back to reset values in 1 cycle, no done.
//   - fondos_insuficientes together with entregar_dinero: status=3.
// - With TECLADO_BCD_CHECK_EN, pin_in=16'h12A4:
//   - status=5, no tarjeta_recibida, no strobes.

Source files
------------

// File: rtl/emisor_teclado.sv
// Keypad-side transmitter for the cashier FSM. It runs one full session per start:
// card insert, 4 PIN digits, wait for the PIN verdict, 8 amount digits plus monto_stb,
// wait for the result, then reports the outcome on done/status.
// Optional build macro TECLADO_BCD_CHECK_EN: reject sessions whose PIN or amount
// contains a nibble above 9 (status 5, no card, no strobes).
module emisor_teclado #(
    parameter int GAP_CYCLES    = 2,
    parameter int INSERT_CYCLES = 4,
    parameter int RESP_TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pin_in,
    input  logic [31:0] monto_in,
    input  logic        tipo_in,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    input  logic        entregar_dinero,
    input  logic        fondos_insuficientes,
    output logic        tarjeta_recibida,
    output logic        tipo_trans,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic        monto_stb,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status
);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int INS_W = (INSERT_CYCLES > 1) ? $clog2(INSERT_CYCLES) : 1;
    localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
    localparam logic [INS_W-1:0] INS_LAST = INS_W'(INSERT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_PIN    = 3'd1;
    localparam logic [2:0] ST_BLOQ   = 3'd2;
    localparam logic [2:0] ST_FONDOS = 3'd3;
    localparam logic [2:0] ST_NORESP = 3'd4;
    localparam logic [2:0] ST_BCD    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_REJECT, S_INSERT, S_SEND_PIN, S_WAIT_PIN, S_SEND_AMT, S_WAIT_RES, S_FINISH
    } state_t;

    state_t           state;
    logic [INS_W-1:0] ins_cnt;
    logic [GAP_W-1:0] ph_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       dig_idx;
    logic [15:0]      pin_q;
    logic [31:0]      monto_q;
    logic             stb_q;
    logic [3:0]       dig_q;
    logic             mstb_q;

    // Nibble idx of the PIN, counted from the most significant end.
    function automatic logic [3:0] pin_nib(input logic [15:0] p, input logic [2:0] idx);
        logic [15:0] sh;
        sh = p << {idx[1:0], 2'b00};
        return sh[15:12];
    endfunction

    // Nibble idx of the amount, counted from the most significant end.
    function automatic logic [3:0] monto_nib(input logic [31:0] m, input logic [2:0] idx);
        logic [31:0] sh;
        sh = m << {idx, 2'b00};
        return sh[31:28];
    endfunction

`ifdef TECLADO_BCD_CHECK_EN
    // True when any nibble of the packed PIN/amount is not a decimal digit.
    function automatic logic has_non_bcd(input logic [47:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (v[4*i +: 4] > 4'h9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // A blocked cashier silences the strobes in the very cycle it is reported.
    assign digito_stb = stb_q & ~bloqueo;
    assign digito     = digito_stb ? dig_q : 4'hF;
    assign monto_stb  = mstb_q & ~bloqueo;

    // Capture the session data when a start is accepted.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            pin_q   <= pin_in;
            monto_q <= monto_in;
        end
    end

    // Session sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            ins_cnt          <= '0;
            ph_cnt           <= '0;
            tmo_cnt          <= '0;
            dig_idx          <= '0;
            stb_q            <= 1'b0;
            dig_q            <= 4'hF;
            mstb_q           <= 1'b0;
            tarjeta_recibida <= 1'b0;
            tipo_trans       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            status           <= ST_OK;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && state != S_FINISH && bloqueo) begin
                state            <= S_FINISH;
                status           <= ST_BLOQ;
                done             <= 1'b1;
                tarjeta_recibida <= 1'b0;
                stb_q            <= 1'b0;
                dig_q            <= 4'hF;
                mstb_q           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            tipo_trans <= tipo_in;
                            status     <= ST_OK;
                            busy       <= 1'b1;
                            ins_cnt    <= '0;
`ifdef TECLADO_BCD_CHECK_EN
                            if (has_non_bcd({pin_in, monto_in})) begin
                                state <= S_REJECT;
                            end else begin
                                state            <= S_INSERT;
                                tarjeta_recibida <= 1'b1;
                            end
`else
                            state            <= S_INSERT;
                            tarjeta_recibida <= 1'b1;
`endif
                        end
                    end
                    S_REJECT: begin
                        state  <= S_FINISH;
                        status <= ST_BCD;
                        done   <= 1'b1;
                    end
                    S_INSERT: begin
                        if (ins_cnt == INS_LAST) begin
                            state   <= S_SEND_PIN;
                            stb_q   <= 1'b1;
                            dig_q   <= pin_q[15:12];
                            dig_idx <= '0;
                            ph_cnt  <= '0;
                        end else begin
                            ins_cnt <= ins_cnt + 1'b1;
                        end
                    end
                    S_SEND_PIN: begin
                        if (ph_cnt == '0 && dig_idx == 3'd3) begin
                            state   <= S_WAIT_PIN;
                            stb_q   <= 1'b0;
                            dig_q   <= 4'hF;
                            tmo_cnt <= '0;
                        end else if (ph_cnt == GAP_LAST) begin
                            ph_cnt  <= '0;
                            dig_idx <= dig_idx + 3'd1;
                            stb_q   <= 1'b1;
                            dig_q   <= pin_nib(pin_q, dig_idx + 3'd1);
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                            stb_q  <= 1'b0;
                            dig_q  <= 4'hF;
                        end
                    end
                    S_WAIT_PIN: begin
                        if (pin_incorrecto) begin
                            state            <= S_FINISH;
                            status           <= ST_PIN;
                            done             <= 1'b1;
                            tarjeta_recibida <= 1'b0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state   <= S_SEND_AMT;
                            stb_q   <= 1'b1;
                            dig_q   <= monto_q[31:28];
                            dig_idx <= '0;
                            ph_cnt  <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_SEND_AMT: begin
                        if (mstb_q) begin
                            state   <= S_WAIT_RES;
                            mstb_q  <= 1'b0;
                            tmo_cnt <= '0;
                        end else if (ph_cnt == GAP_LAST) begin
                            if (dig_idx == 3'd7) begin
                                mstb_q <= 1'b1;
                                stb_q  <= 1'b0;
                                dig_q  <= 4'hF;
                            end else begin
                                ph_cnt  <= '0;
                                dig_idx <= dig_idx + 3'd1;
                                stb_q   <= 1'b1;
                                dig_q   <= monto_nib(monto_q, dig_idx + 3'd1);
                            end
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                            stb_q  <= 1'b0;
                            dig_q  <= 4'hF;
                        end
                    end
                    S_WAIT_RES: begin
                        if (fondos_insuficientes || entregar_dinero || tmo_cnt == TMO_LAST) begin
                            state            <= S_FINISH;
                            done             <= 1'b1;
                            tarjeta_recibida <= 1'b0;
                            if (fondos_insuficientes)  status <= ST_FONDOS;
                            else if (entregar_dinero)  status <= ST_OK;
                            else                       status <= tipo_trans ? ST_NORESP : ST_OK;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_emisor_teclado.sv
// Self-checking bench for emisor_teclado: each session is compared against a
// timeline model built from the session rules (phase start cycles and event windows).
module tb_emisor_teclado;
    localparam int G = 2;
    localparam int I = 4;
    localparam int R = 16;
`ifdef TECLADO_BCD_CHECK_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif
    // Session timeline offsets relative to the start cycle.
    localparam int OFF_PS  = 1 + I;
    localparam int OFF_WPS = OFF_PS + 3 * (G + 1) + 1;
    localparam int OFF_WPE = OFF_WPS + R - 1;
    localparam int OFF_AS  = OFF_WPE + 1;
    localparam int OFF_MS  = OFF_AS + 8 * (G + 1);
    localparam int OFF_WRS = OFF_MS + 1;
    localparam int OFF_WRE = OFF_WRS + R - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pin_in = '0;
    logic [31:0] monto_in = '0;
    logic        tipo_in = 1'b0;
    logic        pin_incorrecto = 1'b0;
    logic        bloqueo = 1'b0;
    logic        entregar_dinero = 1'b0;
    logic        fondos_insuficientes = 1'b0;
    logic        tarjeta_recibida, tipo_trans, digito_stb, monto_stb, busy, done;
    logic [3:0]  digito;
    logic [2:0]  status;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    emisor_teclado #(.GAP_CYCLES(G), .INSERT_CYCLES(I), .RESP_TIMEOUT(R)) dut (
        .clock(clock), .reset(reset), .start(start), .pin_in(pin_in), .monto_in(monto_in),
        .tipo_in(tipo_in), .pin_incorrecto(pin_incorrecto), .bloqueo(bloqueo),
        .entregar_dinero(entregar_dinero), .fondos_insuficientes(fondos_insuficientes),
        .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans), .digito_stb(digito_stb),
        .digito(digito), .monto_stb(monto_stb), .busy(busy), .done(done), .status(status)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    function automatic bit non_bcd(input logic [47:0] v);
        for (int i = 0; i < 12; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // kind: 0 none, 1 pin_incorrecto, 2 bloqueo, 3 fondos, 4 entregar, 5 fondos+entregar.
    task automatic run_session(input string name, input logic [15:0] pin, input logic [31:0] monto,
                               input logic tipo, input int kind, input int ev_off, input int extra_off);
        int s, e, c, exp_done, exp_st, exp_ms, sc;
        bit rej;
        int exp_q[$];
        int obs_q[$];
        int obs_done, obs_st, obs_ms, n_done, n_ms, tj_err, busy_err, prot_err, held_st, bad_idx;
        @(negedge clock);
        s = cyc;
        e = s + ev_off;
        rej = BCD_EN && non_bcd({pin, monto});
        if (rej) begin
            exp_done = s + 2; exp_st = 5;
        end else if (kind == 2 && e >= s + 1 && e <= s + OFF_WRE) begin
            exp_done = e + 1; exp_st = 2;
        end else if (kind == 1 && e >= s + OFF_WPS && e <= s + OFF_WPE) begin
            exp_done = e + 1; exp_st = 1;
        end else if ((kind == 3 || kind == 5) && e >= s + OFF_WRS && e <= s + OFF_WRE) begin
            exp_done = e + 1; exp_st = 3;
        end else if (kind == 4 && e >= s + OFF_WRS && e <= s + OFF_WRE) begin
            exp_done = e + 1; exp_st = 0;
        end else begin
            exp_done = s + OFF_WRE + 1; exp_st = tipo ? 4 : 0;
        end
        exp_ms = -1;
        if (!rej) begin
            for (int k = 0; k < 4; k++) begin
                sc = s + OFF_PS + k * (G + 1);
                if (sc < exp_done - 1) exp_q.push_back((sc << 4) | int'((pin >> (4 * (3 - k))) & 16'hF));
            end
            for (int k = 0; k < 8; k++) begin
                sc = s + OFF_AS + k * (G + 1);
                if (sc < exp_done - 1) exp_q.push_back((sc << 4) | int'((monto >> (4 * (7 - k))) & 32'hF));
            end
            if (s + OFF_MS < exp_done - 1) exp_ms = s + OFF_MS;
        end
        obs_done = -1; obs_st = -1; obs_ms = -1; n_done = 0; n_ms = 0;
        tj_err = 0; busy_err = 0; prot_err = 0; held_st = -1;
        for (int k = 0; k < 300; k++) begin
            c = cyc;
            start = (c == s) || (extra_off > 0 && c == s + extra_off);
            pin_in = (c == s) ? pin : 16'($urandom);
            monto_in = (c == s) ? monto : $urandom;
            tipo_in = (c == s) ? tipo : ~tipo;
            bloqueo = (kind == 2 && c == e);
            pin_incorrecto = (kind == 1 && c == e);
            fondos_insuficientes = ((kind == 3 || kind == 5) && c == e);
            entregar_dinero = ((kind == 4 || kind == 5) && c == e);
            #1;
            if (tarjeta_recibida !== (!rej && c >= s + 1 && c <= exp_done - 1)) tj_err++;
            if (c > s && busy !== (c <= exp_done)) busy_err++;
            if (c > s && tarjeta_recibida === 1'b1 && tipo_trans !== tipo) prot_err++;
            if (digito_stb === 1'b1) obs_q.push_back((c << 4) | int'(digito));
            else if (digito !== 4'hF) prot_err++;
            if (digito_stb === 1'b1 && monto_stb === 1'b1) prot_err++;
            if (monto_stb === 1'b1) begin n_ms++; obs_ms = c; end
            if (done === 1'b1) begin
                n_done++;
                if (obs_done < 0) begin obs_done = c; obs_st = int'(status); end
            end
            if (obs_done >= 0 && c == obs_done + 3) begin held_st = int'(status); break; end
            @(negedge clock);
        end
        start = 1'b0; bloqueo = 1'b0; pin_incorrecto = 1'b0;
        fondos_insuficientes = 1'b0; entregar_dinero = 1'b0;

        checks++;
        if (obs_done != exp_done || n_done != 1) begin
            errors++;
            $display("FAIL %s done: at +%0d (pulses %0d), expected at +%0d (1 pulse)", name, obs_done - s, n_done, exp_done - s);
        end
        checks++;
        if (obs_st != exp_st) begin
            errors++;
            $display("FAIL %s status: got %0d expected %0d", name, obs_st, exp_st);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        bad_idx = -1;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            if (bad_idx < 0 && obs_q[k] != exp_q[k]) bad_idx = k;
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s strobe[%0d]: got +%0d digit %0h expected +%0d digit %0h", name, bad_idx,
                     (obs_q[bad_idx] >> 4) - s, obs_q[bad_idx] & 15, (exp_q[bad_idx] >> 4) - s, exp_q[bad_idx] & 15);
        end
        checks++;
        if ((exp_ms < 0) ? (n_ms != 0) : (n_ms != 1 || obs_ms != exp_ms)) begin
            errors++;
            $display("FAIL %s monto_stb: %0d pulses last at +%0d, expected at +%0d", name, n_ms, obs_ms - s, exp_ms < 0 ? -1 : exp_ms - s);
        end
        checks++;
        if (tj_err != 0) begin
            errors++;
            $display("FAIL %s tarjeta_recibida: %0d wrong cycles, expected 0", name, tj_err);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL %s busy: %0d wrong cycles, expected 0", name, busy_err);
        end
        checks++;
        if (prot_err != 0) begin
            errors++;
            $display("FAIL %s protocol: %0d violations (digito/overlap/tipo), expected 0", name, prot_err);
        end
        checks++;
        if (held_st != exp_st) begin
            errors++;
            $display("FAIL %s status_held: got %0d expected %0d", name, held_st, exp_st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, busy, done, status} !==
            {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: got tj=%b tipo=%b stb=%b dig=%h mstb=%b busy=%b done=%b st=%0d, expected 0/0/0/f/0/0/0/0",
                     tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, busy, done, status);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_deposit_timeout();
        run_session("deposit_timeout", 16'h1234, rand_bcd(), 1'b0, 0, 0, 0);
    endtask

    task automatic test_withdraw_entregar();
        run_session("withdraw_entregar", rand_bcd() >> 16, 32'h00000500, 1'b1, 4, OFF_MS + 5, 0);
    endtask

    task automatic test_withdraw_timeout();
        run_session("withdraw_noresp", 16'h0999, rand_bcd(), 1'b1, 0, 0, 0);
    endtask

    task automatic test_pin_incorrecto();
        run_session("pin_incorrecto", 16'h4321, rand_bcd(), 1'b1, 1, OFF_PS + 3 * (G + 1) + 2, 0);
    endtask

    task automatic test_bloqueo();
        run_session("bloqueo_amt_gap", 16'h5555, 32'h87654321, 1'b1, 2, OFF_AS + 2 * (G + 1) + 1, 0);
        run_session("bloqueo_insert", 16'h1111, 32'h22222222, 1'b0, 2, 2, 0);
    endtask

    task automatic test_start_busy();
        run_session("start_while_busy", 16'h2468, 32'h13579024, 1'b0, 0, 0, 20);
    endtask

    task automatic test_fondos_entregar();
        run_session("fondos_and_entregar", 16'h7777, 32'h00100000, 1'b1, 5, OFF_WRS + 3, 0);
    endtask

    task automatic test_random();
        logic [31:0] p;
        for (int n = 0; n < 6; n++) begin
            p = rand_bcd();
            run_session($sformatf("random%0d", n), p[15:0], rand_bcd(), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 5)), int'($urandom_range(1, OFF_WRE + 3)), 0);
        end
    endtask

    task automatic test_bcd_check();
        run_session("bcd_nibble_A", 16'h12A4, 32'h00001234, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int s, n_stb, bad;
        @(negedge clock);
        s = cyc;
        start = 1'b1; pin_in = 16'h9876; monto_in = 32'h12345678; tipo_in = 1'b1;
        n_stb = 0;
        while (cyc <= s + OFF_PS + G + 1) begin
            #1;
            if (digito_stb === 1'b1) n_stb++;
            @(negedge clock);
            start = 1'b0;
        end
        checks++;
        if (n_stb != 2) begin
            errors++;
            $display("FAIL reset_mid_strobes: got %0d expected 2", n_stb);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, busy, done, status} !==
            {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_values: got tj=%b tipo=%b stb=%b dig=%h mstb=%b busy=%b done=%b st=%0d, expected 0/0/0/f/0/0/0/0",
                     tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, busy, done, status);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || tarjeta_recibida !== 1'b0 || digito_stb !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d active cycles after reset, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_deposit_timeout();
        test_withdraw_entregar();
        test_withdraw_timeout();
        test_pin_incorrecto();
        test_bloqueo();
        test_start_busy();
        test_fondos_entregar();
        test_reset_mid();
        test_bcd_check();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
